// File: rtl/axil_sched_pkg.sv
// Shared definitions for the AXI-Lite request scheduler: FSM state encoding
// and AXI response codes.
package axil_sched_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StResp = 2'd2,
        StGap  = 2'd3
    } state_e;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespExokay = 2'b01;
    localparam logic [1:0] RespSlverr = 2'b10;
    localparam logic [1:0] RespDecerr = 2'b11;

    // SLVERR and DECERR both have the MSB set.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the last
// winner (wrapping). The pointer advances to the winner whenever a grant is
// issued and resets to NUM_REQ-1 so requester 0 wins first.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant
);

    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SumW = PtrW + 1;

    logic [PtrW-1:0] ptr_q;
    logic [PtrW-1:0] ptr_d;
    logic            found;

    // Scan candidates ptr+1 .. ptr+NUM_REQ (mod NUM_REQ); first hit wins.
    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            logic [SumW-1:0] sum;
            logic [PtrW-1:0] idx;
            sum = {1'b0, ptr_q} + SumW'(k);
            if (sum >= SumW'(NUM_REQ)) begin
                sum = sum - SumW'(NUM_REQ);
            end
            idx = sum[PtrW-1:0];
            if (!found && en && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                ptr_d      = idx;
            end
        end
    end

    // Pointer register: remembers the last winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= PtrW'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/axil_lite_req_sched.sv
// Round-robin scheduler sharing one AXI-Lite master between NUM_REQ
// requesters. One transfer in flight; IDLE -> BUSY -> RESP -> GAP -> IDLE.
// Optional completion timeout: define AXIL_SCHED_TIMEOUT_EN.
module axil_lite_req_sched
    import axil_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic                      rsp_error,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [ADDR_W-1:0]         app_waddr,
    output logic [DATA_W-1:0]         app_wdata,
    output logic                      app_wen,
    output logic [ADDR_W-1:0]         app_raddr,
    output logic                      app_ren,
    input  logic [DATA_W-1:0]         app_rdata,
    input  logic                      app_wdone,
    input  logic                      app_werror,
    input  logic                      app_rdone,
    input  logic                      app_rerror
);

    state_e               state_q;
    state_e               state_d;
    logic [NUM_REQ-1:0]   gnt_q;
    logic                 wr_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [1:0]           resp_q;
    logic [DATA_W-1:0]    rdata_q;

    logic                 arb_en;
    logic [NUM_REQ-1:0]   grant;
    logic                 accept;
    logic                 sel_write;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic                 cmpl;
    logic                 cmpl_err;
    logic                 tmo_hit;
    logic                 finish;

    // Arbitration only runs in IDLE, and never while reset is asserted.
    assign arb_en = (state_q == StIdle) && !areset;
    assign accept = |grant;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk   (aclk),
        .rst   (areset),
        .req   (req_valid),
        .en    (arb_en),
        .grant (grant)
    );

    // Select the granted requester's fields (one-hot OR mux).
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant[i]) begin
                sel_write = sel_write | req_write[i];
                sel_addr  = sel_addr  | req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = sel_wdata | req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Completion decode; the inactive direction's inputs are ignored.
    always_comb begin
        cmpl     = wr_q ? (app_wdone | app_werror) : (app_rdone | app_rerror);
        cmpl_err = wr_q ? app_werror : app_rerror;
    end

`ifdef AXIL_SCHED_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] tmo_q;

    // Count BUSY cycles; cleared on entry to BUSY.
    always_ff @(posedge aclk) begin
        if (areset || accept) begin
            tmo_q <= '0;
        end else if (state_q == StBusy) begin
            tmo_q <= tmo_q + CntW'(1);
        end
    end

    // Fires on the last allowed BUSY cycle so the enable is high exactly
    // TIMEOUT_CYCLES cycles.
    assign tmo_hit = (state_q == StBusy) && (tmo_q == CntW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign tmo_hit        = 1'b0;
`endif

    assign finish = (state_q == StBusy) && (cmpl || tmo_hit);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StBusy;
            StBusy: if (cmpl || tmo_hit) state_d = StResp;
            StResp: state_d = StGap;
            StGap:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latch and response capture; error wins over done.
    always_ff @(posedge aclk) begin
        if (areset) begin
            gnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            resp_q  <= RespOkay;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                gnt_q   <= grant;
                wr_q    <= sel_write;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end
            if (finish) begin
                resp_q <= (!cmpl || cmpl_err) ? RespSlverr : RespOkay;
                if (cmpl && !wr_q) begin
                    rdata_q <= app_rdata;
                end
            end
        end
    end

    // Output decode from state and latched request.
    always_comb begin
        req_ready = grant;
        app_wen   = (state_q == StBusy) && wr_q;
        app_ren   = (state_q == StBusy) && !wr_q;
        app_waddr = addr_q;
        app_raddr = addr_q;
        app_wdata = wdata_q;
        rsp_valid = (state_q == StResp) ? gnt_q : '0;
        rsp_error = (state_q == StResp) && resp_is_err(resp_q);
        rsp_rdata = rdata_q;
    end

endmodule
